// File: rtl/fir_coef_ctrl.sv
// fir_coef_ctrl: double-buffered coefficient loader and sample gate for a 9-tap FIR.
// Coefficient sets are staged in a shadow bank, and the shadow is copied to the active
// bank only after the FIR has drained. Samples are forwarded only while an active set
// exists and no swap is in progress.
// Define FIR_COEF_CTRL_DROP_CNT_EN to build the saturating dropped-sample counter.
// Without it, DROP_CNT is tied to 0.
module fir_coef_ctrl #(
   parameter int NB    = 11,
   parameter int NTAPS = 9,
   parameter int DRAIN = 2,
   parameter int CNTW  = 16
) (
   input  logic                 CLK,
   input  logic                 RST_n,
   input  logic                 CFG_VALID,
   input  logic signed [NB-1:0] CFG_DATA,
   output logic                 CFG_READY,
   input  logic                 S_VIN,
   input  logic        [NB-1:0] S_DIN,
   output logic                 F_VIN,
   output logic        [NB-1:0] F_DIN,
   output logic signed [NB-1:0] H0,
   output logic signed [NB-1:0] H1,
   output logic signed [NB-1:0] H2,
   output logic signed [NB-1:0] H3,
   output logic signed [NB-1:0] H4,
   output logic signed [NB-1:0] H5,
   output logic signed [NB-1:0] H6,
   output logic signed [NB-1:0] H7,
   output logic signed [NB-1:0] H8,
   output logic                 COEF_OK,
   output logic                 SWAP_BUSY,
   output logic      [CNTW-1:0] DROP_CNT
);
   localparam int IW = $clog2(NTAPS);
   localparam int CW = $clog2(DRAIN + 2);
   typedef enum logic [1:0] {EMPTY, RUN, SWAP} state_t;
   state_t             r_state, w_next;
   logic [IW-1:0]      r_idx;
   logic               r_pending;
   logic [CW-1:0]      r_cnt;
   logic signed [NB-1:0] r_shadow [NTAPS];
   logic signed [NB-1:0] r_active [NTAPS];
   logic               w_acc, w_last, w_commit, w_pend_next, w_drop;
   assign w_acc       = CFG_VALID && CFG_READY;
   assign w_last      = w_acc && (r_idx == IW'(NTAPS - 1));
   assign w_commit    = (r_state == EMPTY && r_pending) || (r_state == SWAP && r_cnt == CW'(DRAIN));
   assign w_pend_next = w_last || (r_pending && !w_commit);
   assign w_drop      = S_VIN && (r_state != RUN);
   assign COEF_OK     = (r_state != EMPTY);
   assign SWAP_BUSY   = (r_state == SWAP);
   assign H0 = r_active[0];
   assign H1 = r_active[1];
   assign H2 = r_active[2];
   assign H3 = r_active[3];
   assign H4 = r_active[4];
   assign H5 = r_active[5];
   assign H6 = r_active[6];
   assign H7 = r_active[7];
   assign H8 = r_active[8];
   // State register.
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) r_state <= EMPTY;
      else        r_state <= w_next;
   end
   // Next state: a commit always lands in RUN; a pending set in RUN starts a swap.
   always_comb begin
      w_next = r_state;
      if (w_commit) w_next = RUN;
      else if (r_state == RUN && r_pending) w_next = SWAP;
   end
   // Load index, pending flag, swap drain timer, and registered ready.
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         r_idx     <= '0;
         r_pending <= 1'b0;
         r_cnt     <= '0;
         CFG_READY <= 1'b0;
      end else begin
         if (w_acc) r_idx <= w_last ? '0 : r_idx + IW'(1);
         r_pending <= w_pend_next;
         r_cnt     <= (r_state == SWAP) ? r_cnt + CW'(1) : '0;
         CFG_READY <= !w_pend_next && (w_next != SWAP);
      end
   end
   // Shadow bank takes accepted words; active bank is copied from the shadow on commit.
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         for (int i = 0; i < NTAPS; i++) begin
            r_shadow[i] <= '0;
            r_active[i] <= '0;
         end
      end else begin
         if (w_acc) r_shadow[r_idx] <= CFG_DATA;
         if (w_commit) r_active <= r_shadow;
      end
   end
   // Sample gate: forward with one cycle of latency in RUN; hold F_DIN otherwise.
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         F_VIN <= 1'b0;
         F_DIN <= '0;
      end else begin
         F_VIN <= S_VIN && (r_state == RUN);
         if (S_VIN && r_state == RUN) F_DIN <= S_DIN;
      end
   end
`ifdef FIR_COEF_CTRL_DROP_CNT_EN
   logic [CNTW-1:0] r_drop;
   assign DROP_CNT = r_drop;
   // Saturating count of samples refused while empty or swapping.
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) r_drop <= '0;
      else if (w_drop && r_drop != '1) r_drop <= r_drop + CNTW'(1);
   end
`else
   logic w_unused_drop;
   assign w_unused_drop = w_drop;
   assign DROP_CNT = '0;
`endif
endmodule

// File: tb/tb_fir_coef_ctrl.sv
// tb_fir_coef_ctrl: directed scenario tests for fir_coef_ctrl.
module tb_fir_coef_ctrl;
   localparam int NB = 11;
`ifdef FIR_COEF_CTRL_DROP_CNT_EN
   localparam bit DC = 1'b1;
`else
   localparam bit DC = 1'b0;
`endif
   logic CLK = 1'b0, RST_n = 1'b0, CFG_VALID = 1'b0, CFG_READY, S_VIN = 1'b0, F_VIN, COEF_OK, SWAP_BUSY;
   logic signed [NB-1:0] CFG_DATA = '0;
   logic [NB-1:0] S_DIN = '0, F_DIN;
   logic signed [NB-1:0] H0, H1, H2, H3, H4, H5, H6, H7, H8;
   logic [15:0] DROP_CNT;
   logic [NB-1:0] h [9];
   int total = 0, bad = 0;
   assign h[0] = H0; assign h[1] = H1; assign h[2] = H2;
   assign h[3] = H3; assign h[4] = H4; assign h[5] = H5;
   assign h[6] = H6; assign h[7] = H7; assign h[8] = H8;

   fir_coef_ctrl dut (
      .CLK(CLK), .RST_n(RST_n), .CFG_VALID(CFG_VALID), .CFG_DATA(CFG_DATA), .CFG_READY(CFG_READY),
      .S_VIN(S_VIN), .S_DIN(S_DIN), .F_VIN(F_VIN), .F_DIN(F_DIN),
      .H0(H0), .H1(H1), .H2(H2), .H3(H3), .H4(H4), .H5(H5), .H6(H6), .H7(H7), .H8(H8),
      .COEF_OK(COEF_OK), .SWAP_BUSY(SWAP_BUSY), .DROP_CNT(DROP_CNT)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      #2;
      total++; if (CFG_READY !== 1'b0) begin bad++; $display("FAIL reset_ready got=%0b exp=0", CFG_READY); end
      total++; if (F_VIN !== 1'b0 || F_DIN !== '0) begin bad++; $display("FAIL reset_fout got=%0b/%0d exp=0/0", F_VIN, F_DIN); end
      total++; if (COEF_OK !== 1'b0 || SWAP_BUSY !== 1'b0) begin bad++; $display("FAIL reset_flags got=%0b%0b exp=00", COEF_OK, SWAP_BUSY); end
      total++; if (DROP_CNT !== 16'd0) begin bad++; $display("FAIL reset_drop got=%0d exp=0", DROP_CNT); end
      for (int i = 0; i < 9; i++) begin
         total++; if (h[i] !== '0) begin bad++; $display("FAIL reset_h%0d got=%0d exp=0", i, h[i]); end
      end
      RST_n = 1'b1;
      tick();
      total++; if (CFG_READY !== 1'b1) begin bad++; $display("FAIL ready_after_reset got=%0b exp=1", CFG_READY); end
   endtask

   task automatic test_empty_drop();
      S_VIN = 1'b1;
      S_DIN = 11'd77;
      for (int i = 0; i < 5; i++) begin
         tick();
         total++; if (F_VIN !== 1'b0) begin bad++; $display("FAIL empty_fvin cyc=%0d got=%0b exp=0", i, F_VIN); end
      end
      S_VIN = 1'b0;
      total++; if (COEF_OK !== 1'b0) begin bad++; $display("FAIL empty_coef_ok got=%0b exp=0", COEF_OK); end
      total++; if (DROP_CNT !== (DC ? 16'd5 : 16'd0)) begin bad++; $display("FAIL empty_drop got=%0d exp=%0d", DROP_CNT, DC ? 5 : 0); end
   endtask

   task automatic test_load_first(input int base);
      for (int k = 0; k < 9; k++) begin
         total++; if (CFG_READY !== 1'b1) begin bad++; $display("FAIL load_ready k=%0d got=%0b exp=1", k, CFG_READY); end
         CFG_VALID = 1'b1;
         CFG_DATA = NB'(base + k);
         tick();
      end
      CFG_VALID = 1'b0;
      total++; if (CFG_READY !== 1'b0) begin bad++; $display("FAIL load_ready_drop got=%0b exp=0", CFG_READY); end
      total++; if (COEF_OK !== 1'b0 || H0 !== '0) begin bad++; $display("FAIL load_early got=%0b/%0d exp=0/0", COEF_OK, H0); end
      tick();
      for (int i = 0; i < 9; i++) begin
         total++; if (h[i] !== NB'(base + i)) begin bad++; $display("FAIL load_h%0d got=%0d exp=%0d", i, h[i], base + i); end
      end
      total++; if (COEF_OK !== 1'b1 || CFG_READY !== 1'b1 || SWAP_BUSY !== 1'b0) begin bad++; $display("FAIL load_done got=ok%0b rdy%0b busy%0b exp=ok1 rdy1 busy0", COEF_OK, CFG_READY, SWAP_BUSY); end
   endtask

   task automatic test_stream();
      S_VIN = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         S_DIN = NB'(100 * k);
         tick();
         total++; if (F_VIN !== 1'b1 || F_DIN !== NB'(100 * k)) begin bad++; $display("FAIL stream k=%0d got=%0b/%0d exp=1/%0d", k, F_VIN, F_DIN, 100 * k); end
      end
      S_VIN = 1'b0;
      S_DIN = 11'd5;
      tick();
      total++; if (F_VIN !== 1'b0 || F_DIN !== 11'd300) begin bad++; $display("FAIL stream_hold got=%0b/%0d exp=0/300", F_VIN, F_DIN); end
   endtask

   task automatic test_swap();
      S_VIN = 1'b1;
      for (int k = 0; k < 9; k++) begin
         CFG_VALID = 1'b1;
         CFG_DATA = NB'(10 + k);
         S_DIN = NB'(500 + k);
         tick();
         total++; if (F_VIN !== 1'b1 || F_DIN !== NB'(500 + k)) begin bad++; $display("FAIL swap_load_fwd k=%0d got=%0b/%0d exp=1/%0d", k, F_VIN, F_DIN, 500 + k); end
      end
      CFG_VALID = 1'b0;
      total++; if (CFG_READY !== 1'b0 || SWAP_BUSY !== 1'b0 || H0 !== 11'd1) begin bad++; $display("FAIL swap_pend got=rdy%0b busy%0b h0=%0d exp=rdy0 busy0 h0=1", CFG_READY, SWAP_BUSY, H0); end
      S_DIN = 11'd600;
      tick();
      total++; if (F_VIN !== 1'b1 || F_DIN !== 11'd600 || SWAP_BUSY !== 1'b1) begin bad++; $display("FAIL swap_enter got=%0b/%0d busy%0b exp=1/600 busy1", F_VIN, F_DIN, SWAP_BUSY); end
      for (int k = 1; k <= 2; k++) begin
         S_DIN = NB'(600 + k);
         tick();
         total++; if (F_VIN !== 1'b0 || F_DIN !== 11'd600 || SWAP_BUSY !== 1'b1 || H0 !== 11'd1 || CFG_READY !== 1'b0) begin bad++; $display("FAIL swap_mid k=%0d got=%0b/%0d busy%0b h0=%0d rdy%0b exp=0/600 busy1 h0=1 rdy0", k, F_VIN, F_DIN, SWAP_BUSY, H0, CFG_READY); end
      end
      S_DIN = 11'd603;
      tick();
      total++; if (F_VIN !== 1'b0 || SWAP_BUSY !== 1'b0 || CFG_READY !== 1'b1) begin bad++; $display("FAIL swap_exit got=vin%0b busy%0b rdy%0b exp=vin0 busy0 rdy1", F_VIN, SWAP_BUSY, CFG_READY); end
      for (int i = 0; i < 9; i++) begin
         total++; if (h[i] !== NB'(10 + i)) begin bad++; $display("FAIL swap_h%0d got=%0d exp=%0d", i, h[i], 10 + i); end
      end
      S_DIN = 11'd604;
      tick();
      total++; if (F_VIN !== 1'b1 || F_DIN !== 11'd604) begin bad++; $display("FAIL swap_first_run got=%0b/%0d exp=1/604", F_VIN, F_DIN); end
      S_VIN = 1'b0;
      total++; if (DROP_CNT !== (DC ? 16'd8 : 16'd0)) begin bad++; $display("FAIL swap_drop got=%0d exp=%0d", DROP_CNT, DC ? 8 : 0); end
   endtask

   task automatic test_reset_mid_load();
      for (int k = 0; k < 4; k++) begin
         CFG_VALID = 1'b1;
         CFG_DATA = NB'(50 + k);
         tick();
      end
      RST_n = 1'b0;
      CFG_VALID = 1'b0;
      #1;
      total++; if (CFG_READY !== 1'b0 || COEF_OK !== 1'b0 || H0 !== '0 || F_VIN !== 1'b0 || DROP_CNT !== 16'd0) begin bad++; $display("FAIL async_reset got=rdy%0b ok%0b h0=%0d vin%0b drop%0d exp=all0", CFG_READY, COEF_OK, H0, F_VIN, DROP_CNT); end
      #2;
      RST_n = 1'b1;
      tick();
      test_load_first(1);
   endtask

   task automatic test_hold_valid_swap();
      CFG_VALID = 1'b1;
      for (int k = 0; k < 9; k++) begin
         CFG_DATA = NB'(20 + k);
         tick();
      end
      CFG_DATA = 11'd99;
      for (int k = 0; k < 4; k++) begin
         total++; if (CFG_READY !== 1'b0) begin bad++; $display("FAIL hold_ready k=%0d got=%0b exp=0", k, CFG_READY); end
         tick();
      end
      total++; if (CFG_READY !== 1'b1 || H0 !== 11'd20 || H8 !== 11'd28) begin bad++; $display("FAIL hold_commit got=rdy%0b h0=%0d h8=%0d exp=rdy1 h0=20 h8=28", CFG_READY, H0, H8); end
      for (int k = 0; k < 9; k++) begin
         CFG_DATA = NB'(30 + k);
         tick();
      end
      CFG_VALID = 1'b0;
      for (int k = 0; k < 4; k++) tick();
      for (int i = 0; i < 9; i++) begin
         total++; if (h[i] !== NB'(30 + i)) begin bad++; $display("FAIL hold_h%0d got=%0d exp=%0d", i, h[i], 30 + i); end
      end
   endtask

   initial begin
      test_reset();
      test_empty_drop();
      test_load_first(1);
      test_stream();
      test_swap();
      test_reset_mid_load();
      test_hold_valid_swap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/fir_coef_ctrl.md
Name: fir_coef_ctrl

Overview:
- Configuration and sequencing controller placed between the sample source (data_gen) and the 9-tap, 11-bit FIR (myfir).
- Loads coefficient sets into a shadow bank through a valid/ready handshake and drives H0..H8 from an active bank.
- Swaps banks only after the FIR pipeline has drained, so no output mixes old and new coefficients.
- Gates the sample stream into the filter: samples are forwarded only while a committed coefficient set exists and no swap is in progress.

Parameters:
NB, 11, coefficient and sample width in bits
NTAPS, 9, number of coefficients (H0..H8)
DRAIN, 2, FIR input-to-output latency in cycles; number of cycles the FIR input is held idle before a bank swap
CNTW, 16, width of the dropped-sample counter

Ports:
CLK  in  1  system clock, all state updates on rising edge
RST_n  in  1  asynchronous active-low reset
CFG_VALID  in  1  coefficient word valid
CFG_DATA  in  NB  coefficient word, signed; sent in order H0 first, H8 last
CFG_READY  out  1  controller can accept a coefficient word
S_VIN  in  1  source sample valid (from data_gen)
S_DIN  in  NB  source sample
F_VIN  out  1  sample valid to FIR VIN
F_DIN  out  NB  sample to FIR DIN
H0..H8  out  NB each  active coefficients to FIR
COEF_OK  out  1  an active coefficient set exists
SWAP_BUSY  out  1  state is SWAP
DROP_CNT  out  CNTW  samples dropped since reset (see Optional Feature)

Behaviour:
- Reset, asynchronous and applied immediately:
  - state = EMPTY; shadow index = 0; pending = 0.
  - All shadow and active coefficients = 0.
  - CFG_READY=0, F_VIN=0, F_DIN=0, H0..H8=0, COEF_OK=0, SWAP_BUSY=0, DROP_CNT=0.
  - CFG_READY rises on the first clock after reset deassertion.
- Config handshake:
  - A word is accepted when CFG_VALID && CFG_READY at a rising edge; it is written to shadow[idx] and idx increments.
  - On acceptance of word NTAPS-1, idx wraps to 0 and pending is set.
  - CFG_READY = !pending && state != SWAP (registered). It is 0 from the edge after the last word until the swap completes.
  - CFG_DATA is ignored when CFG_VALID is low.
- States:
  - EMPTY:
    - F_VIN=0; every S_VIN=1 is dropped.
    - When pending is set: on the next edge, active <= shadow, pending cleared, COEF_OK=1, go to RUN. No drain is needed because the FIR has never been fed.
  - RUN:
    - F_VIN/F_DIN <= S_VIN/S_DIN, registered, 1-cycle latency. No drops.
    - Shadow loading is allowed while running (double buffering).
    - When pending is set, go to SWAP on the next edge.
    - If the last config word and a sample arrive in the same cycle, the sample is forwarded.
  - SWAP:
    - Lasts exactly DRAIN+1 cycles. F_VIN=0; S_VIN=1 samples are dropped.
    - On the edge that leaves SWAP: active <= shadow, pending cleared, go to RUN.
    - Samples presented in the first RUN cycle are forwarded.
- H0..H8 change only on the edges described above and are otherwise stable.
- F_DIN holds its last value when F_VIN=0.
- Reset asserted mid-load or mid-swap discards the partial shadow, the pending flag and the active set; the block returns to the full reset state.

Optional Feature:
- Macro FIR_COEF_CTRL_DROP_CNT_EN.
- Defined:
  - DROP_CNT increments by 1 for each S_VIN=1 seen in EMPTY or SWAP.
  - It saturates at 2^CNTW-1 and is cleared only by reset.
- Undefined:
  - No counter logic is built; DROP_CNT is tied to 0.
  - Drop behaviour is otherwise identical.

Test Plan:
- Reset, then S_VIN=1 for 5 cycles with no configuration -> F_VIN stays 0, COEF_OK=0, DROP_CNT=5 (with macro) or 0 (without).
- Load 9 words 1..9 back-to-back -> CFG_READY drops after the 9th word; 1 cycle later H0..H8=1..9, COEF_OK=1, state RUN, CFG_READY=1 again.
- In RUN, drive S_DIN=100,200,300 on consecutive cycles -> F_DIN=100,200,300 with F_VIN=1, each exactly 1 cycle later.
- In RUN with continuous S_VIN, load new set 10..18 -> SWAP_BUSY=1 for 3 cycles (DRAIN=2), F_VIN=0 and 3 samples dropped, H switches to 10..18 on the exit edge; the FIR's last old-set output appears before any new-set sample enters.
- Load 4 words, assert RST_n=0 mid-cycle, then load 1..9 -> H0..H8=1..9, proving the partial set was discarded and the index reset.
- Hold CFG_VALID=1 throughout SWAP -> no word accepted until CFG_READY returns; the next set starts at H0.
